// File: rtl/lf_edge_interval_capture_pkg.sv
// Shared constants for the LF edge-interval capture block: default widths,
// record layout (level in the MSB above the count) and arming FSM encodings.
package lf_edge_interval_capture_pkg;

  localparam int unsigned LF_CNT_W   = 12;
  localparam int unsigned LF_FIFO_AW = 3;

  // Record layout: {level, count}; level sits at bit offset CNT_W.
  localparam int unsigned LF_REC_CNT_LSB = 0;

  localparam logic [0:0] ST_DISARMED = 1'b0;
  localparam logic [0:0] ST_ARMED    = 1'b1;

endpackage

// File: rtl/lf_edge_interval_capture_if.sv
// Readout interface for the interval capture FIFO: head record, occupancy and
// sticky overflow towards the consumer, rd_ready back from it.
interface lf_edge_interval_capture_if
  import lf_edge_interval_capture_pkg::*;
#(
  parameter int unsigned CNT_W   = LF_CNT_W,
  parameter int unsigned FIFO_AW = LF_FIFO_AW
);

  logic               rd_valid;
  logic               rd_ready;
  logic               rd_level;
  logic [CNT_W-1:0]   rd_count;
  logic [FIFO_AW:0]   fifo_level;
  logic               overflow;

  modport master (
    output rd_valid,
    output rd_level,
    output rd_count,
    output fifo_level,
    output overflow,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_level,
    input  rd_count,
    input  fifo_level,
    input  overflow,
    output rd_ready
  );

endinterface

// File: rtl/lf_sync_fifo.sv
// Single-clock FIFO with a registered head word, occupancy count and
// synchronous flush. Push and pop may coincide, including when full.
module lf_sync_fifo
  import lf_edge_interval_capture_pkg::*;
#(
  parameter int unsigned W  = LF_CNT_W + 1,
  parameter int unsigned AW = LF_FIFO_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          valid_o,
  output logic          full_c_o,
  output logic [AW:0]   level_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          valid_q, valid_d;
  logic          full;
  logic          pop;
  logic          wr_en;

  // Next pointers, count and head; pop is only honoured while a record is visible.
  always_comb begin
    full       = (cnt_q == (AW+1)'(DEPTH));
    pop        = pop_i & valid_q & ~flush_i;
    wr_en      = push_i & (~full | pop) & ~flush_i;
    rd_ptr_nxt = rd_ptr_q + AW'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    head_d     = head_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      head_d   = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_nxt;
      cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      // With one entry left the successor is the word being written this edge.
      if (pop) begin
        if (cnt_q > (AW+1)'(1))  head_d = mem_q[rd_ptr_nxt];
        else if (wr_en)          head_d = wdata_i;
      end else if ((cnt_q == '0) && wr_en) begin
        head_d = wdata_i;
      end
    end
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o  = head_q;
  assign valid_o  = valid_q;
  assign full_c_o = full;
  assign level_o  = cnt_q;

endmodule

// File: rtl/lf_edge_interval_capture.sv
// Measures clk cycles between successive lf_edge_detect edges and queues
// {level, interval} records for the readout consumer.
module lf_edge_interval_capture
  import lf_edge_interval_capture_pkg::*;
#(
  parameter int unsigned CNT_W   = LF_CNT_W,
  parameter int unsigned FIFO_AW = LF_FIFO_AW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_i,
  input  logic                        edge_state_i,
  input  logic                        edge_toggle_i,
  lf_edge_interval_capture_if.master  rd
);

  localparam int unsigned REC_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             toggle_q;
  logic             state_q;
  logic [0:0]       arm_q, arm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             evt;
  logic             push;
  logic [REC_W-1:0] fifo_rdata;
  logic             fifo_valid;
  logic             fifo_full;
  logic [FIFO_AW:0] fifo_level;

  assign evt = enable_i & (edge_toggle_i ^ toggle_q);

  // Arming FSM, saturating interval counter and sticky overflow.
  always_comb begin
    arm_d = arm_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    push  = 1'b0;

    if (!enable_i) begin
      arm_d = ST_DISARMED;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      case (arm_q)
        ST_DISARMED: begin
          if (evt) begin
            arm_d = ST_ARMED;
            cnt_d = CNT_W'(1);
          end
        end
        ST_ARMED: begin
          if (evt) begin
            push  = 1'b1;
            cnt_d = CNT_W'(1);
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: arm_d = ST_DISARMED;
      endcase
      // A full FIFO only makes room when the consumer pops on this same edge.
      if (push && fifo_full && !rd.rd_ready) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= 1'b0;
      state_q  <= 1'b0;
      arm_q    <= ST_DISARMED;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      toggle_q <= edge_toggle_i;
      state_q  <= edge_state_i;
      arm_q    <= arm_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  lf_sync_fifo #(
    .W  (REC_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (~enable_i),
    .push_i   (push),
    .wdata_i  ({state_q, cnt_q}),
    .pop_i    (rd.rd_ready),
    .rdata_o  (fifo_rdata),
    .valid_o  (fifo_valid),
    .full_c_o (fifo_full),
    .level_o  (fifo_level)
  );

  assign rd.rd_valid   = fifo_valid;
  assign rd.rd_level   = fifo_rdata[CNT_W];
  assign rd.rd_count   = fifo_rdata[CNT_W-1:LF_REC_CNT_LSB];
  assign rd.fifo_level = fifo_level;
  assign rd.overflow   = ovf_q;

endmodule

// File: tb/tb_lf_edge_interval_capture.sv
// Directed bench for lf_edge_interval_capture: drives edge_toggle/edge_state like
// lf_edge_detect and scores popped records against a queue of expected records.
module tb_lf_edge_interval_capture;
  import lf_edge_interval_capture_pkg::*;

  localparam int unsigned CNT_W   = LF_CNT_W;
  localparam int unsigned FIFO_AW = LF_FIFO_AW;
  localparam int          DEPTH   = 8;
  localparam int          CMAX    = 4095;

  logic clk, clk_run, rst_n, enable, edge_state, edge_toggle;

  lf_edge_interval_capture_if #(.CNT_W(CNT_W), .FIFO_AW(FIFO_AW)) rd_if ();

  lf_edge_interval_capture #(.CNT_W(CNT_W), .FIFO_AW(FIFO_AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .edge_state_i  (edge_state),
    .edge_toggle_i (edge_toggle),
    .rd            (rd_if)
  );

  // Gated so an asynchronous reset can be applied with no clock edge around it.
  always #1 clk = clk_run ? ~clk : 1'b0;

  int               n_vec;
  int               n_err;
  int               since;
  bit               armed_m;
  bit               exp_ovf;
  logic [CNT_W:0]   exp_q[$];
  logic             cap_v;
  logic [CNT_W:0]   cap_h;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    since++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_gap(input int n);
    while (since < n) tick();
  endtask

  // Emit one detected edge; the interval just closed is expected if armed.
  task automatic do_edge();
    logic [CNT_W:0] rec;
    if (armed_m) begin
      rec = {edge_state, CNT_W'(since > CMAX ? CMAX : since)};
      if (exp_q.size() >= DEPTH && rd_if.rd_ready !== 1'b1) exp_ovf = 1'b1;
      else exp_q.push_back(rec);
    end
    armed_m     = 1'b1;
    edge_state  = ~edge_state;
    edge_toggle = ~edge_toggle;
    since       = 0;
  endtask

  task automatic chk_out_zero(input string pfx);
    chk({pfx, "_valid"}, 32'(rd_if.rd_valid), 0);
    chk({pfx, "_rlevel"}, 32'(rd_if.rd_level), 0);
    chk({pfx, "_count"}, 32'(rd_if.rd_count), 0);
    chk({pfx, "_fifo_level"}, 32'(rd_if.fifo_level), 0);
    chk({pfx, "_overflow"}, 32'(rd_if.overflow), 0);
  endtask

  always @(negedge clk) begin
    cap_v = rd_if.rd_valid;
    cap_h = {rd_if.rd_level, rd_if.rd_count};
  end

  // Scoreboard: a handshake at this edge consumes the head seen half a cycle earlier.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && enable === 1'b1 && cap_v === 1'b1 && rd_if.rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        assert (0) else begin
          n_err++;
          $error("FAIL extra_record: observed %0h, expected none", cap_h);
        end
      end else begin
        chk("rd_record", 32'(cap_h), 32'(exp_q.pop_front()));
      end
    end
  end

  int gaps2[3] = '{10, 15, 75};

  initial begin
    n_vec = 0; n_err = 0; since = 0; armed_m = 0; exp_ovf = 0; cap_v = 0;
    clk = 0; clk_run = 1; rst_n = 0; enable = 0;
    edge_state = 0; edge_toggle = 0; rd_if.rd_ready = 0;

    ticks(2);
    chk_out_zero("reset");
    rst_n = 1;
    enable = 1;
    rd_if.rd_ready = 1;
    tick();

    // Regular 32-cycle edges: first only arms, then one record per edge.
    wait_gap(5);
    do_edge();
    tick();
    chk("arm_only_valid", 32'(rd_if.rd_valid), 0);
    for (int i = 0; i < 4; i++) begin
      wait_gap(32);
      do_edge();
      tick();
      chk("t1_latency_valid", 32'(rd_if.rd_valid), 1);
      chk("t1_fifo_level", 32'(rd_if.fifo_level), 1);
    end

    // Irregular spacing.
    for (int i = 0; i < 3; i++) begin
      wait_gap(gaps2[i]);
      do_edge();
      tick();
      chk("t2_valid", 32'(rd_if.rd_valid), 1);
    end

    // Long gap saturates; the next interval starts again from 1.
    wait_gap(5000);
    do_edge();
    tick();
    chk("t3_sat_valid", 32'(rd_if.rd_valid), 1);
    wait_gap(7);
    do_edge();
    tick();
    tick();

    // Consumer stalled: FIFO fills, extra records are dropped.
    rd_if.rd_ready = 0;
    for (int i = 0; i < 10; i++) begin
      wait_gap(4 + i);
      do_edge();
    end
    tick();
    chk("t4_fifo_level", 32'(rd_if.fifo_level), 32'(exp_q.size()));
    chk("t4_full", 32'(rd_if.fifo_level), DEPTH);
    chk("t4_overflow", 32'(rd_if.overflow), 32'(exp_ovf));
    chk("t4_head", 32'({rd_if.rd_level, rd_if.rd_count}), 32'(exp_q[0]));

    // Push and pop on the same edge while full.
    wait_gap(6);
    rd_if.rd_ready = 1;
    do_edge();
    tick();
    rd_if.rd_ready = 0;
    chk("t4_pushpop_level", 32'(rd_if.fifo_level), DEPTH);
    chk("t4_pushpop_ovf", 32'(rd_if.overflow), 1);
    chk("t4_pushpop_head", 32'({rd_if.rd_level, rd_if.rd_count}), 32'(exp_q[0]));

    rd_if.rd_ready = 1;
    ticks(3);
    rd_if.rd_ready = 0;
    tick();
    chk("t5_level_before_flush", 32'(rd_if.fifo_level), 5);

    // One-cycle disable with a toggle change hidden inside it.
    enable = 0;
    edge_toggle = ~edge_toggle;
    edge_state = ~edge_state;
    exp_q.delete();
    armed_m = 0;
    exp_ovf = 0;
    tick();
    enable = 1;
    chk("t5_flush_level", 32'(rd_if.fifo_level), 0);
    chk("t5_flush_ovf", 32'(rd_if.overflow), 0);
    chk("t5_flush_valid", 32'(rd_if.rd_valid), 0);
    ticks(3);
    chk("t5_no_phantom_event", 32'(rd_if.rd_valid), 0);
    rd_if.rd_ready = 1;
    wait_gap(4);
    do_edge();
    tick();
    chk("t5_rearm_only", 32'(rd_if.rd_valid), 0);
    wait_gap(20);
    do_edge();
    tick();
    chk("t5_first_record_valid", 32'(rd_if.rd_valid), 1);
    tick();

    // Asynchronous reset mid-interval with records queued.
    rd_if.rd_ready = 0;
    wait_gap(9);
    do_edge();
    wait_gap(11);
    do_edge();
    ticks(7);
    chk("t6_level_before_reset", 32'(rd_if.fifo_level), 32'(exp_q.size()));
    clk_run = 0;
    #1;
    rst_n = 0;
    #1;
    chk_out_zero("t6_async");
    edge_toggle = 0;
    edge_state = 0;
    exp_q.delete();
    armed_m = 0;
    exp_ovf = 0;
    rst_n = 1;
    #1;
    clk_run = 1;
    since = 0;
    tick();
    rd_if.rd_ready = 1;
    wait_gap(3);
    do_edge();
    tick();
    chk("t6_rearm_only", 32'(rd_if.rd_valid), 0);
    wait_gap(12);
    do_edge();
    tick();
    chk("t6_record_valid", 32'(rd_if.rd_valid), 1);

    ticks(5);
    chk("drain_pending", 32'(exp_q.size()), 0);
    chk("final_valid", 32'(rd_if.rd_valid), 0);
    chk("final_overflow", 32'(rd_if.overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
